// File: rtl/call_dispatcher.sv
// call_dispatcher: collects hall/cabin requests into a pending-floor bitmap and
// feeds the elevator one target at a time using a SCAN (keep-direction) policy.
// A dispatched floor is retired when the car drops busy (or never acknowledges)
// and is cleared only if the car actually stopped at the target.
module call_dispatcher #(
    parameter int unsigned FLOORS      = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hall_req_i,
    input  logic [2:0] hall_f_i,
    input  logic       cab_req_i,
    input  logic [2:0] cab_f_i,
    input  logic [2:0] elev_f_i,
    input  logic       busy_i,
    output logic [2:0] pass_f_o,
    output logic       call_o,
    output logic [7:0] pending_o,
    output logic       dir_up_o,
    output logic       miss_o
);

    localparam int unsigned CW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]    NF   = 4'(FLOORS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    pending_q, pending_d;
    logic [2:0]    pass_f_q, pass_f_d;
    logic          dir_up_q, dir_up_d;
    logic          miss_q, miss_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [7:0]    set_mask;
    logic [7:0]    clr_mask;
    logic          retire;

    logic          have_ge, have_gt, have_le, have_lt;
    logic [2:0]    lo_ge, lo_gt, hi_le, hi_lt;
    logic [2:0]    idx_up, idx_dn;
    logic [2:0]    sel_f;
    logic          sel_dir;

    // Decode incoming request pulses; out-of-range floors never reach the bitmap
    always_comb begin
        set_mask = '0;
        if (hall_req_i && ({1'b0, hall_f_i} < NF)) begin
            set_mask[hall_f_i] = 1'b1;
        end
        if (cab_req_i && ({1'b0, cab_f_i} < NF)) begin
            set_mask[cab_f_i] = 1'b1;
        end
    end

    // SCAN target pick: nearest pending floor ahead in the current direction, else reverse
    always_comb begin
        have_ge = 1'b0;
        have_gt = 1'b0;
        have_le = 1'b0;
        have_lt = 1'b0;
        lo_ge   = '0;
        lo_gt   = '0;
        hi_le   = '0;
        hi_lt   = '0;
        idx_up  = '0;
        idx_dn  = '0;
        // Ascending scan keeps the last (highest) hit, descending scan the last (lowest) hit
        for (int unsigned k = 0; k < FLOORS; k++) begin
            idx_up = 3'(k);
            idx_dn = 3'(FLOORS - 1 - k);
            if (pending_q[idx_up] && (idx_up <= elev_f_i)) begin
                have_le = 1'b1;
                hi_le   = idx_up;
            end
            if (pending_q[idx_up] && (idx_up < elev_f_i)) begin
                have_lt = 1'b1;
                hi_lt   = idx_up;
            end
            if (pending_q[idx_dn] && (idx_dn >= elev_f_i)) begin
                have_ge = 1'b1;
                lo_ge   = idx_dn;
            end
            if (pending_q[idx_dn] && (idx_dn > elev_f_i)) begin
                have_gt = 1'b1;
                lo_gt   = idx_dn;
            end
        end
        sel_f   = '0;
        sel_dir = dir_up_q;
        if (dir_up_q) begin
            if (have_ge) begin
                sel_f = lo_ge;
            end else if (have_lt) begin
                sel_f   = hi_lt;
                sel_dir = 1'b0;
            end
        end else begin
            if (have_le) begin
                sel_f = hi_le;
            end else if (have_gt) begin
                sel_f   = lo_gt;
                sel_dir = 1'b1;
            end
        end
    end

    // Dispatch FSM next state, retire decision and bitmap update (set wins over clear)
    always_comb begin
        state_d  = state_q;
        pass_f_d = pass_f_q;
        dir_up_d = dir_up_q;
        miss_d   = miss_q;
        cnt_d    = cnt_q;
        retire   = 1'b0;
        clr_mask = '0;
        unique case (state_q)
            IDLE: begin
                if ((pending_q != '0) && !busy_i) begin
                    pass_f_d = sel_f;
                    dir_up_d = sel_dir;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == LAST) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy_i) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (retire) begin
            if (elev_f_i == pass_f_q) begin
                clr_mask[pass_f_q] = 1'b1;
            end else begin
                miss_d = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            pass_f_q  <= '0;
            dir_up_q  <= 1'b1;
            miss_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pass_f_q  <= pass_f_d;
            dir_up_q  <= dir_up_d;
            miss_q    <= miss_d;
            cnt_q     <= cnt_d;
        end
    end

    assign call_o    = (state_q == ISSUE);
    assign pass_f_o  = pass_f_q;
    assign pending_o = pending_q;
    assign dir_up_o  = dir_up_q;
    assign miss_o    = miss_q;

endmodule
